// File: rtl/io_port_ctrl_pkg.sv
// Shared register map, bit positions and status layout for the board I/O controller.
package io_pkg;

  localparam int unsigned IO_STATUS   = 0;
  localparam int unsigned IO_LEDSH    = 1;
  localparam int unsigned IO_SWDATA   = 2;
  localparam int unsigned IO_SWLIVE   = 3;
  localparam int unsigned IO_PRESSCNT = 4;
  localparam int unsigned IO_CTRL     = 5;

  localparam int unsigned ST_LED_DONE = 0;
  localparam int unsigned ST_SW_VALID = 1;
  localparam int unsigned ST_SW_OVR   = 2;
  localparam int unsigned ST_LED_PEND = 3;

  localparam int unsigned CTRL_LED_AUTO  = 0;
  localparam int unsigned CTRL_DB_BYPASS = 1;

  // Field order matches the STATUS bit positions above (led_done in bit 0).
  typedef struct packed {
    logic led_pend;
    logic sw_ovr;
    logic sw_valid;
    logic led_done;
  } status_t;

  typedef struct packed {
    logic db_bypass;
    logic led_auto;
  } ctrl_t;

endpackage

// File: rtl/io_port_ctrl_if.sv
// CPU data-memory bus as seen by the I/O controller: level read strobe, edge-acted write strobe.
interface io_port_ctrl_if #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 32
);

  logic              pread;
  logic              pwrite;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] pwritedata;
  logic [DATA_W-1:0] preaddata;

  modport master (
    output pread,
    output pwrite,
    output addr,
    output pwritedata,
    input  preaddata
  );

  modport slave (
    input  pread,
    input  pwrite,
    input  addr,
    input  pwritedata,
    output preaddata
  );

endinterface

// File: rtl/io_port_ctrl_btn_debounce.sv
// One push-button path: 2-FF synchroniser, stability-counter debounce and a one-cycle press pulse.
module btn_debounce #(
  parameter int unsigned DB_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic bypass,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic          meta_q;
  logic          sync_q;
  logic          deb_q;
  logic          deb_d;
  logic          deb_prev_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] limit;

  // >= rather than == so that enabling bypass with a partial count still flips at once.
  assign limit = bypass ? '0 : CW'(DB_CYCLES - 1);

  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (sync_q != deb_q) begin
      if (cnt_q >= limit) begin
        deb_d = ~deb_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q     <= 1'b0;
      sync_q     <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      meta_q     <= raw;
      sync_q     <= meta_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      cnt_q      <= cnt_d;
    end
  end

  assign level = deb_q;
  assign press = deb_q & ~deb_prev_q;

endmodule

// File: rtl/io_port_ctrl.sv
// Memory-mapped board I/O controller: switches, LEDs and two debounced push-buttons
// behind a register file with W1C sticky status, press counters and LED auto-update.
module io_port_ctrl
  import io_pkg::*;
#(
  parameter int unsigned SW_W      = 16,
  parameter int unsigned LED_W     = 12,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 3,
  parameter int unsigned DB_CYCLES = 100000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  io_port_ctrl_if.slave    bus,
  input  logic             buttonl,
  input  logic             buttonr,
  input  logic [SW_W-1:0]  switch,
  output logic [LED_W-1:0] led
);

  logic [SW_W-1:0]   sw_meta_q;
  logic [SW_W-1:0]   sw_sync_q;
  logic [SW_W-1:0]   snap_q;
  logic [SW_W-1:0]   snap_d;
  logic [LED_W-1:0]  led_q;
  logic [LED_W-1:0]  led_d;
  logic [LED_W-1:0]  shadow_q;
  logic [LED_W-1:0]  shadow_d;
  status_t           status_q;
  status_t           status_d;
  ctrl_t             ctrl_q;
  ctrl_t             ctrl_d;
  logic [CNT_W-1:0]  cnt_l_q;
  logic [CNT_W-1:0]  cnt_l_d;
  logic [CNT_W-1:0]  cnt_r_q;
  logic [CNT_W-1:0]  cnt_r_d;
  logic [DATA_W-1:0] rdata;

  logic level_l;
  logic level_r;
  logic press_l;
  logic press_r;

  logic wr_status;
  logic wr_ledsh;
  logic wr_cnt;
  logic wr_ctrl;
  logic rd_swdata;
  logic clr_valid;

  logic unused_bits;
  assign unused_bits = ^{bus.pwritedata, level_l, level_r};

  btn_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_btn_l (
    .clk    (clk),
    .reset  (reset),
    .bypass (ctrl_q.db_bypass),
    .raw    (buttonl),
    .level  (level_l),
    .press  (press_l)
  );

  btn_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_btn_r (
    .clk    (clk),
    .reset  (reset),
    .bypass (ctrl_q.db_bypass),
    .raw    (buttonr),
    .level  (level_r),
    .press  (press_r)
  );

  assign wr_status = bus.pwrite && (bus.addr == ADDR_W'(IO_STATUS));
  assign wr_ledsh  = bus.pwrite && (bus.addr == ADDR_W'(IO_LEDSH));
  assign wr_cnt    = bus.pwrite && (bus.addr == ADDR_W'(IO_PRESSCNT));
  assign wr_ctrl   = bus.pwrite && (bus.addr == ADDR_W'(IO_CTRL));
  assign rd_swdata = bus.pread  && (bus.addr == ADDR_W'(IO_SWDATA));

  assign clr_valid = (wr_status && bus.pwritedata[ST_SW_VALID]) || rd_swdata;

  always_comb begin
    status_d = status_q;
    led_d    = led_q;
    shadow_d = shadow_q;
    snap_d   = snap_q;
    ctrl_d   = ctrl_q;
    cnt_l_d  = cnt_l_q;
    cnt_r_d  = cnt_r_q;

    // Switch capture: a press always re-validates; overrun only if the previous
    // snapshot was still unread and is not being consumed this same cycle.
    if (press_r) begin
      snap_d            = sw_sync_q;
      status_d.sw_valid = 1'b1;
      if (status_q.sw_valid && !clr_valid) begin
        status_d.sw_ovr = 1'b1;
      end
    end else if (clr_valid) begin
      status_d.sw_valid = 1'b0;
    end
    if (!(press_r && status_q.sw_valid && !clr_valid) &&
        wr_status && bus.pwritedata[ST_SW_OVR]) begin
      status_d.sw_ovr = 1'b0;
    end

    // LED path: the press copies the pre-edge shadow, an auto-mode write overrides it.
    if (press_l) begin
      led_d = shadow_q;
    end
    if (wr_ledsh) begin
      shadow_d = bus.pwritedata[LED_W-1:0];
      if (ctrl_q.led_auto) begin
        led_d = bus.pwritedata[LED_W-1:0];
      end
    end

    if (wr_ledsh) begin
      status_d.led_done = 1'b0;
    end else if (press_l) begin
      status_d.led_done = 1'b1;
    end else if (wr_status && bus.pwritedata[ST_LED_DONE]) begin
      status_d.led_done = 1'b0;
    end

    if (wr_ledsh) begin
      status_d.led_pend = !ctrl_q.led_auto;
    end else if (press_l) begin
      status_d.led_pend = 1'b0;
    end else if (wr_status && bus.pwritedata[ST_LED_PEND]) begin
      status_d.led_pend = 1'b0;
    end

    if (wr_cnt) begin
      cnt_l_d = '0;
      cnt_r_d = '0;
    end else begin
      cnt_l_d = cnt_l_q + CNT_W'(press_l);
      cnt_r_d = cnt_r_q + CNT_W'(press_r);
    end

    if (wr_ctrl) begin
      ctrl_d.led_auto  = bus.pwritedata[CTRL_LED_AUTO];
      ctrl_d.db_bypass = bus.pwritedata[CTRL_DB_BYPASS];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      snap_q    <= '0;
      led_q     <= '0;
      shadow_q  <= '0;
      status_q  <= '0;
      ctrl_q    <= '0;
      cnt_l_q   <= '0;
      cnt_r_q   <= '0;
    end else begin
      sw_meta_q <= switch;
      sw_sync_q <= sw_meta_q;
      snap_q    <= snap_d;
      led_q     <= led_d;
      shadow_q  <= shadow_d;
      status_q  <= status_d;
      ctrl_q    <= ctrl_d;
      cnt_l_q   <= cnt_l_d;
      cnt_r_q   <= cnt_r_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (bus.pread) begin
      case (bus.addr)
        ADDR_W'(IO_STATUS):   rdata[3:0]         = status_q;
        ADDR_W'(IO_LEDSH):    rdata[LED_W-1:0]   = shadow_q;
        ADDR_W'(IO_SWDATA):   rdata[SW_W-1:0]    = snap_q;
        ADDR_W'(IO_SWLIVE):   rdata[SW_W-1:0]    = sw_sync_q;
        ADDR_W'(IO_PRESSCNT): rdata[2*CNT_W-1:0] = {cnt_r_q, cnt_l_q};
        ADDR_W'(IO_CTRL):     rdata[1:0]         = ctrl_q;
        default:              rdata              = '0;
      endcase
    end
  end

  assign bus.preaddata = rdata;
  assign led           = led_q;

endmodule
